cisr_run_ctrl: RTL and testbench



---
 rtl/cisr_pkg.sv | 19 +
 rtl/cisr_wb_filter.sv | 84 ++++++++
 rtl/cisr_run_ctrl.sv | 160 ++++++++++++++++
 tb/tb_cisr_run_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cisr_pkg.sv
// Shared types and default widths for the CISR run controller.
package cisr_pkg;

    localparam int CHANNELS     = 4;
    localparam int CH_W         = $clog2(CHANNELS);
    localparam int ROW_LEN_W    = 8;
    localparam int ROW_ID_W     = 16;
    localparam int ACC_W        = 32;
    localparam int CLEAR_CYCLES = 2;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        PAD,
        DONE
    } state_e;

endpackage

// File: rtl/cisr_wb_filter.sv
// Accumulator writeback filter: drops warm-up slot fills and pad rows,
// counts genuine row results and registers them onto the result port.
module cisr_wb_filter
#(
    parameter int CHANNELS = cisr_pkg::CHANNELS,
    parameter int CH_W     = $clog2(CHANNELS),
    parameter int ROW_ID_W = cisr_pkg::ROW_ID_W,
    parameter int ACC_W    = cisr_pkg::ACC_W
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                active,
    input  logic [ROW_ID_W-1:0] num_rows,
    input  logic                acc_wr_valid,
    input  logic [ROW_ID_W-1:0] acc_wr_addr,
    input  logic [ACC_W-1:0]    acc_wr_data,
    output logic                res_we,
    output logic [ROW_ID_W-1:0] res_addr,
    output logic [ACC_W-1:0]    res_data,
    output logic                all_written
);

    localparam int CNT_W = ROW_ID_W + 1;
    localparam logic [CH_W:0] WARM_MAX = (CH_W + 1)'(CHANNELS);

    logic [CH_W:0]         warm_q, warm_d;
    logic [CNT_W-1:0]      rows_written_q, rows_written_d;
    logic                  res_we_q, res_we_d;
    logic [ROW_ID_W-1:0]   res_addr_q, res_addr_d;
    logic [ACC_W-1:0]      res_data_q, res_data_d;
    logic                  warm_done;
    logic                  fwd;

    always_comb begin
        warm_d         = warm_q;
        rows_written_d = rows_written_q;
        res_addr_d     = res_addr_q;
        res_data_d     = res_data_q;

        warm_done = (warm_q == WARM_MAX);
        fwd       = active && acc_wr_valid && warm_done && (acc_wr_addr < num_rows);
        res_we_d  = fwd;

        if (clr) begin
            warm_d         = '0;
            rows_written_d = '0;
        end else begin
            if (active && acc_wr_valid && !warm_done)
                warm_d = warm_q + (CH_W + 1)'(1);
            if (fwd)
                rows_written_d = rows_written_q + CNT_W'(1);
        end

        if (fwd) begin
            res_addr_d = acc_wr_addr;
            res_data_d = acc_wr_data;
        end

        // Looks one cycle ahead so done lines up with the final res_we.
        all_written = (rows_written_d == {1'b0, num_rows});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            warm_q         <= '0;
            rows_written_q <= '0;
            res_we_q       <= 1'b0;
            res_addr_q     <= '0;
            res_data_q     <= '0;
        end else begin
            warm_q         <= warm_d;
            rows_written_q <= rows_written_d;
            res_we_q       <= res_we_d;
            res_addr_q     <= res_addr_d;
            res_data_q     <= res_data_d;
        end
    end

    assign res_we   = res_we_q;
    assign res_addr = res_addr_q;
    assign res_data = res_data_q;

endmodule

// File: rtl/cisr_run_ctrl.sv
// Per-run sequencer for the CISR accumulator: clear, route row lengths,
// pad idle channels, filter writebacks and signal completion.
module cisr_run_ctrl
#(
    parameter int CHANNELS  = cisr_pkg::CHANNELS,
    parameter int CH_W      = $clog2(CHANNELS),
    parameter int ROW_LEN_W = cisr_pkg::ROW_LEN_W,
    parameter int ROW_ID_W  = cisr_pkg::ROW_ID_W,
    parameter int ACC_W     = cisr_pkg::ACC_W
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ROW_ID_W-1:0]  num_rows,
    output logic                 busy,
    output logic                 done,
    input  logic                 rl_in_valid,
    output logic                 rl_in_ready,
    input  logic [ROW_LEN_W-1:0] rl_in_data,
    input  logic [CH_W-1:0]      rl_in_chan,
    output logic [CHANNELS-1:0]  rl_push,
    output logic [ROW_LEN_W-1:0] rl_push_data,
    input  logic [CHANNELS-1:0]  rl_full,
    output logic                 acc_rst,
    input  logic                 acc_wr_valid,
    input  logic [ROW_ID_W-1:0]  acc_wr_addr,
    input  logic [ACC_W-1:0]     acc_wr_data,
    output logic                 res_we,
    output logic [ROW_ID_W-1:0]  res_addr,
    output logic [ACC_W-1:0]     res_data
);

    import cisr_pkg::*;

    localparam int CNT_W = ROW_ID_W + 1;
    localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);

    state_e              state_q, state_d;
    logic [ROW_ID_W-1:0] num_rows_q, num_rows_d;
    logic [CNT_W-1:0]    rows_issued_q, rows_issued_d;
    logic [CLR_W-1:0]    clr_cnt_q, clr_cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                acc_rst_q, acc_rst_d;
    logic                rl_accept;
    logic                all_written;
    logic                filter_clr;
    logic                filter_active;

    // Row-length routing is combinational so a beat lands in its FIFO the cycle it is accepted.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        rl_push      = '0;
        rl_push_data = '0;
        rl_in_ready  = (state_q == RUN) && !rl_full[rl_in_chan];
        rl_accept    = rl_in_valid && rl_in_ready;

        case (state_q)
            RUN: begin
                if (rl_accept) begin
                    rl_push[rl_in_chan] = 1'b1;
                    rl_push_data        = rl_in_data;
                end
            end
            PAD:     rl_push = ~rl_full;
            default: ;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        num_rows_d    = num_rows_q;
        rows_issued_d = rows_issued_q;
        clr_cnt_d     = clr_cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = CLEAR;
                    num_rows_d    = num_rows;
                    rows_issued_d = '0;
                    clr_cnt_d     = '0;
                end
            end
            CLEAR: begin
                if (clr_cnt_q == CLR_W'(CLEAR_CYCLES - 1))
                    state_d = (num_rows_q == '0) ? DONE : RUN;
                else
                    clr_cnt_d = clr_cnt_q + CLR_W'(1);
            end
            RUN: begin
                if (rl_accept)
                    rows_issued_d = rows_issued_q + CNT_W'(1);
                if (all_written)
                    state_d = DONE;
                else if (rows_issued_d == {1'b0, num_rows_q})
                    state_d = PAD;
            end
            PAD: begin
                if (all_written)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
        acc_rst_d = (state_d == IDLE) || (state_d == CLEAR) || (state_d == DONE);
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            num_rows_q    <= '0;
            rows_issued_q <= '0;
            clr_cnt_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            acc_rst_q     <= 1'b1;
        end else begin
            state_q       <= state_d;
            num_rows_q    <= num_rows_d;
            rows_issued_q <= rows_issued_d;
            clr_cnt_q     <= clr_cnt_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            acc_rst_q     <= acc_rst_d;
        end
    end

    assign filter_clr    = (state_q == IDLE);
    assign filter_active = (state_q == RUN) || (state_q == PAD);

    cisr_wb_filter #(
        .CHANNELS (CHANNELS),
        .CH_W     (CH_W),
        .ROW_ID_W (ROW_ID_W),
        .ACC_W    (ACC_W)
    ) u_wb_filter (
        .clk          (clk),
        .rst          (rst),
        .clr          (filter_clr),
        .active       (filter_active),
        .num_rows     (num_rows_q),
        .acc_wr_valid (acc_wr_valid),
        .acc_wr_addr  (acc_wr_addr),
        .acc_wr_data  (acc_wr_data),
        .res_we       (res_we),
        .res_addr     (res_addr),
        .res_data     (res_data),
        .all_written  (all_written)
    );

    assign busy    = busy_q;
    assign done    = done_q;
    assign acc_rst = acc_rst_q;

endmodule

// File: tb/tb_cisr_run_ctrl.sv
// Directed bench for cisr_run_ctrl: basic run, backpressure, padding,
// empty matrix, start handling and mid-run reset.
module tb_cisr_run_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] num_rows;
    logic        busy;
    logic        done;
    logic        rl_in_valid;
    logic        rl_in_ready;
    logic [7:0]  rl_in_data;
    logic [1:0]  rl_in_chan;
    logic [3:0]  rl_push;
    logic [7:0]  rl_push_data;
    logic [3:0]  rl_full;
    logic        acc_rst;
    logic        acc_wr_valid;
    logic [15:0] acc_wr_addr;
    logic [31:0] acc_wr_data;
    logic        res_we;
    logic [15:0] res_addr;
    logic [31:0] res_data;

    int errors = 0;
    int checks = 0;

    int lens [6]     = '{2, 1, 3, 0, 2, 1};
    int t1_addr [6]  = '{1, 2, 6, 3, 4, 5};
    int t2_addr [8]  = '{0, 0, 0, 0, 2, 3, 0, 1};
    int t2_data [8]  = '{11, 12, 13, 14, 15, 16, 55, 66};
    int t2_we [8]    = '{0, 0, 0, 0, 0, 0, 1, 1};

    cisr_run_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_rows     (num_rows),
        .busy         (busy),
        .done         (done),
        .rl_in_valid  (rl_in_valid),
        .rl_in_ready  (rl_in_ready),
        .rl_in_data   (rl_in_data),
        .rl_in_chan   (rl_in_chan),
        .rl_push      (rl_push),
        .rl_push_data (rl_push_data),
        .rl_full      (rl_full),
        .acc_rst      (acc_rst),
        .acc_wr_valid (acc_wr_valid),
        .acc_wr_addr  (acc_wr_addr),
        .acc_wr_data  (acc_wr_data),
        .res_we       (res_we),
        .res_addr     (res_addr),
        .res_data     (res_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        num_rows     = '0;
        rl_in_valid  = 1'b0;
        rl_in_data   = '0;
        rl_in_chan   = '0;
        rl_full      = '0;
        acc_wr_valid = 1'b0;
        acc_wr_addr  = '0;
        acc_wr_data  = '0;
        tick();
        tick();

        check("rst_busy",      64'(busy), 0);
        check("rst_done",      64'(done), 0);
        check("rst_ready",     64'(rl_in_ready), 0);
        check("rst_push",      64'(rl_push), 0);
        check("rst_push_data", 64'(rl_push_data), 0);
        check("rst_res_we",    64'(res_we), 0);
        check("rst_res_addr",  64'(res_addr), 0);
        check("rst_res_data",  64'(res_data), 0);
        check("rst_acc_rst",   64'(acc_rst), 1);
        rst = 1'b0;

        // Basic run: 6 rows round-robin over 4 channels.
        start    = 1'b1;
        num_rows = 16'd6;
        #1;
        check("idle_ready",   64'(rl_in_ready), 0);
        check("idle_acc_rst", 64'(acc_rst), 1);
        tick();
        start    = 1'b0;
        num_rows = 16'd0;
        check("clear_busy",    64'(busy), 1);
        check("clear_acc_rst", 64'(acc_rst), 1);
        check("clear_done",    64'(done), 0);
        rl_in_valid = 1'b1;
        rl_in_data  = 8'd5;
        #1;
        check("clear_ready", 64'(rl_in_ready), 0);
        check("clear_push",  64'(rl_push), 0);
        tick();
        check("clear2_acc_rst", 64'(acc_rst), 1);
        tick();
        check("run_acc_rst", 64'(acc_rst), 0);

        for (int i = 0; i < 6; i++) begin
            rl_in_valid  = 1'b1;
            rl_in_chan   = 2'(i % 4);
            rl_in_data   = 8'(lens[i]);
            acc_wr_valid = (i < 4) || (i == 5);
            acc_wr_addr  = 16'd0;
            acc_wr_data  = (i == 5) ? 32'd100 : 32'hDEAD_0000 + 32'(i);
            #1;
            check("run_ready",     64'(rl_in_ready), 1);
            check("run_push",      64'(rl_push), 64'(1 << (i % 4)));
            check("run_push_data", 64'(rl_push_data), 64'(lens[i]));
            tick();
            check("run_res_we", 64'(res_we), (i == 5) ? 1 : 0);
        end
        check("final_issue_res_addr", 64'(res_addr), 0);
        check("final_issue_res_data", 64'(res_data), 100);

        rl_full      = 4'b0100;
        acc_wr_valid = 1'b0;
        #1;
        check("pad_ready",     64'(rl_in_ready), 0);
        check("pad_push",      64'(rl_push), 64'(4'b1011));
        check("pad_push_data", 64'(rl_push_data), 0);

        for (int k = 0; k < 6; k++) begin
            acc_wr_valid = 1'b1;
            acc_wr_addr  = 16'(t1_addr[k]);
            acc_wr_data  = 32'(100 + t1_addr[k]);
            tick();
            check("t1_res_we", 64'(res_we), (t1_addr[k] < 6) ? 1 : 0);
            if (t1_addr[k] < 6) begin
                check("t1_res_addr", 64'(res_addr), 64'(t1_addr[k]));
                check("t1_res_data", 64'(res_data), 64'(100 + t1_addr[k]));
            end
            check("t1_done", 64'(done), (k == 5) ? 1 : 0);
        end
        check("t1_done_busy", 64'(busy), 1);
        acc_wr_valid = 1'b0;
        rl_in_valid  = 1'b0;
        rl_full      = '0;
        tick();
        check("t1_idle_done",    64'(done), 0);
        check("t1_idle_busy",    64'(busy), 0);
        check("t1_idle_acc_rst", 64'(acc_rst), 1);
        check("t1_idle_res_we",  64'(res_we), 0);

        // Backpressure on channel 2, then padding with num_rows=2.
        start    = 1'b1;
        num_rows = 16'd2;
        tick();
        start = 1'b0;
        tick();
        tick();
        rl_in_valid = 1'b1;
        rl_in_chan  = 2'd2;
        rl_in_data  = 8'd7;
        rl_full     = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            #1;
            check("bp_ready", 64'(rl_in_ready), 0);
            check("bp_push",  64'(rl_push), 0);
            tick();
        end
        rl_full = '0;
        #1;
        check("bp_release_ready",     64'(rl_in_ready), 1);
        check("bp_release_push",      64'(rl_push), 64'(4'b0100));
        check("bp_release_push_data", 64'(rl_push_data), 7);
        tick();
        rl_in_chan = 2'd3;
        rl_in_data = 8'd9;
        #1;
        check("t2_last_push", 64'(rl_push), 64'(4'b1000));
        tick();
        rl_full = 4'b0001;
        #1;
        check("t2_pad_ready",     64'(rl_in_ready), 0);
        check("t2_pad_push",      64'(rl_push), 64'(4'b1110));
        check("t2_pad_push_data", 64'(rl_push_data), 0);
        rl_in_valid = 1'b0;

        for (int k = 0; k < 8; k++) begin
            acc_wr_valid = 1'b1;
            acc_wr_addr  = 16'(t2_addr[k]);
            acc_wr_data  = 32'(t2_data[k]);
            tick();
            check("t2_res_we", 64'(res_we), 64'(t2_we[k]));
            if (t2_we[k] == 1) begin
                check("t2_res_addr", 64'(res_addr), 64'(t2_addr[k]));
                check("t2_res_data", 64'(res_data), 64'(t2_data[k]));
            end
            check("t2_done", 64'(done), (k == 7) ? 1 : 0);
        end
        acc_wr_valid = 1'b0;
        rl_full      = '0;
        tick();
        check("t2_idle_busy", 64'(busy), 0);

        // Empty matrix: CLEAR for 2 cycles then straight to DONE.
        start    = 1'b1;
        num_rows = 16'd0;
        tick();
        start        = 1'b0;
        rl_in_valid  = 1'b1;
        acc_wr_valid = 1'b1;
        acc_wr_addr  = 16'd0;
        #1;
        check("t3_clear_ready", 64'(rl_in_ready), 0);
        check("t3_clear_push",  64'(rl_push), 0);
        tick();
        check("t3_clear2_done", 64'(done), 0);
        tick();
        check("t3_done",        64'(done), 1);
        check("t3_done_busy",   64'(busy), 1);
        check("t3_done_res_we", 64'(res_we), 0);
        check("t3_done_push",   64'(rl_push), 0);
        check("t3_done_acc_rst", 64'(acc_rst), 1);
        tick();
        check("t3_idle_done", 64'(done), 0);
        check("t3_idle_busy", 64'(busy), 0);
        check("t3_idle_res_we", 64'(res_we), 0);

        // Restart in the IDLE cycle right after done, then mid-run reset.
        rl_in_valid  = 1'b0;
        acc_wr_valid = 1'b0;
        start        = 1'b1;
        num_rows     = 16'd8;
        tick();
        start = 1'b0;
        check("t4_busy", 64'(busy), 1);
        tick();
        tick();
        check("t4_run_acc_rst", 64'(acc_rst), 0);
        for (int i = 0; i < 3; i++) begin
            rl_in_valid = 1'b1;
            rl_in_chan  = 2'(i);
            rl_in_data  = 8'(i + 1);
            start       = (i == 1);
            num_rows    = (i == 1) ? 16'd3 : 16'd8;
            #1;
            check("t4_push", 64'(rl_push), 64'(1 << i));
            tick();
        end
        start       = 1'b0;
        rl_in_valid = 1'b0;
        #1;
        check("t4_start_ignored_ready", 64'(rl_in_ready), 1);
        check("t4_idle_push",           64'(rl_push), 0);
        rst = 1'b1;
        tick();
        check("t4_rst_busy",    64'(busy), 0);
        check("t4_rst_acc_rst", 64'(acc_rst), 1);
        check("t4_rst_done",    64'(done), 0);
        check("t4_rst_res_we",  64'(res_we), 0);
        rl_in_valid = 1'b1;
        #1;
        check("t4_rst_ready", 64'(rl_in_ready), 0);
        check("t4_rst_push",  64'(rl_push), 0);
        rst          = 1'b0;
        acc_wr_valid = 1'b1;
        acc_wr_addr  = 16'd0;
        tick();
        check("t4_post_res_we_a", 64'(res_we), 0);
        tick();
        check("t4_post_res_we_b", 64'(res_we), 0);
        check("t4_post_push",     64'(rl_push), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
